// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: 16-bit unsigned restoring divider, one quotient bit per cycle.
// A division takes 16 CALC cycles followed by a single-cycle DONE pulse.
// Optional macro DIV_ZERO_FAST_EN: when defined, a zero divisor skips CALC and
// reports the divide-by-zero result one cycle after the start edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// CALC  | one restoring step per cycle, 16 steps in total
// DONE  | result registers valid, done pulses for one cycle
module seq_divider_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] divisor_q;
    logic [16:0] rem_q;
    logic [15:0] quo_q;
    logic [3:0]  cnt_q;
    logic [15:0] quotient_q;
    logic [15:0] remainder_q;
    logic        dbz_q;

    logic [16:0] shifted;
    logic [17:0] trial;
    logic        trial_neg;
    logic [16:0] rem_step;
    logic [15:0] quo_step;
    logic        last_step;
    logic        zero_div_in;

    // One restoring step: shift the next dividend bit into R and try to subtract D.
    // R never exceeds 16 significant bits, so the top bit of the 18-bit trial is the sign.
    always_comb begin
        shifted   = {rem_q[15:0], quo_q[15]};
        trial     = {rem_q, quo_q[15]} - {2'b00, divisor_q};
        trial_neg = trial[17];
        rem_step  = trial_neg ? shifted : trial[16:0];
        quo_step  = {quo_q[14:0], ~trial_neg};
        last_step = (cnt_q == 4'd15);
        zero_div_in = (divisor == 16'd0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = zero_div_in ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registers that only
    // change on the final step so partial values never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q   <= 16'd0;
            rem_q       <= 17'd0;
            quo_q       <= 16'd0;
            cnt_q       <= 4'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divisor_q <= divisor;
                        quo_q     <= dividend;
                        rem_q     <= 17'd0;
                        cnt_q     <= 4'd0;
                        dbz_q     <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        if (zero_div_in) begin
                            quotient_q  <= 16'hFFFF;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_step) begin
                        quotient_q  <= quo_step;
                        remainder_q <= rem_step[15:0];
                        dbz_q       <= (divisor_q == 16'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: doc/seq_divider_16bit.md
SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 The block SHALL have no parameters: 16-bit operand width, fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  16  unsigned numerator; sampled with start.
REQ-006 divisor  input  16  unsigned denominator; sampled with start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 quotient  output  16  unsigned quotient; held until next accepted start.
REQ-010 remainder  output  16  unsigned remainder; held until next accepted start.
REQ-011 div_by_zero  output  1  set with done when captured divisor == 0; held with the result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 IDLE->CALC on a rising edge with start=1: capture dividend and divisor, clear the 17-bit partial remainder, set the step counter to 0, clear div_by_zero.
REQ-014 Each CALC cycle SHALL do one restoring step: trial = {R[15:0], Q[15]} - {1'b0, D}; if trial is non-negative, R = trial and shift 1 into Q; else R = {R[15:0], Q[15]} and shift 0 into Q. The step counter increments.
REQ-015 After the 16th CALC step, the FSM SHALL go to DONE. quotient and remainder SHALL update on that same edge.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: done is high in the 17th cycle after the start-sampling edge, i.e. 16 edges after the sampling edge.
REQ-018 start SHALL be ignored in CALC and DONE. No queuing; operands changing during CALC have no effect.
REQ-019 start held high continuously SHALL begin a new division on the edge after DONE (back-to-back period 18 cycles).
REQ-020 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for divisor != 0.
REQ-021 For divisor == 0: quotient = 16'hFFFF, remainder = dividend, div_by_zero = 1.
REQ-022 dividend == 0 with divisor != 0 SHALL give quotient = 0 and remainder = 0 after full latency.
REQ-023 Intermediate quotient/remainder values SHALL never be visible on the outputs.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal registers=0.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN:
- Defined: IDLE with start=1 and divisor==0 SHALL go directly to DONE, with done high 1 cycle after the sampling edge and results per REQ-021.
- Undefined: divisor==0 SHALL run the full 16 CALC steps (natural restoring result per REQ-021), with done at the REQ-017 latency and div_by_zero=1.

Verification
REQ-028 Reset mid-CALC (step 7) -> all outputs 0 immediately; no done; next start accepted normally.
REQ-029 dividend=1000, divisor=7, start pulse -> busy next cycle; done 16 edges after sampling; quotient=142, remainder=6, div_by_zero=0.
REQ-030 dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0. dividend=5, divisor=16'hFFFF -> quotient=0, remainder=5.
REQ-031 dividend=1234, divisor=0 -> quotient=16'hFFFF, remainder=1234, div_by_zero=1. done at 1 cycle latency with DIV_ZERO_FAST_EN, 16 edges without.
REQ-032 start re-pulsed mid-CALC with new operands -> ignored; original result returned. start held high -> second result done exactly 18 cycles after the first.
REQ-033 Random 10k operand pairs -> REQ-020 holds for every done; outputs stable between done pulses.
